uart_tx_buffer: RTL and testbench
=================================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter: DEPTH, 16, FIFO depth in bytes; SHALL be a power of two, 4..64.
REQ-002 Port: i_Clock  in  1  single clock; all logic SHALL be rising-edge.
REQ-003 Port: i_Rst_L  in  1  asynchronous active-low reset; assert async, deassert sync to i_Clock.
REQ-004 Port: i_Wr_DV  in  1  one-cycle byte-write strobe from the upstream controller.
REQ-005 Port: i_Wr_Byte  in  8  byte written when i_Wr_DV=1.
REQ-006 Port: o_TX_DV  out  1  one-cycle launch pulse to the UART serializer.
REQ-007 Port: o_TX_Byte  out  8  byte presented to the serializer, held stable from launch until done.
REQ-008 Port: i_TX_Active  in  1  serializer busy.
REQ-009 Port: i_TX_Done  in  1  serializer one-cycle completion pulse.
REQ-010 Port: o_Count  out  log2(DEPTH)+1  current occupancy.
REQ-011 Port: o_Full, o_Empty  out  1 each  occupancy flags.
REQ-012 Port: o_Overflow  out  1  sticky flag: a write was dropped.
REQ-013 Port: i_Clr_Ovf  in  1  synchronous clear of o_Overflow (and o_Ovf_Count when compiled in).

Function
REQ-014 FIFO SHALL be circular; read/write pointers log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-015 Write with o_Full=0 SHALL store i_Wr_Byte at the edge it is sampled; o_Count increments the same edge.
REQ-016 Write with o_Full=1 and no pop that edge SHALL be dropped and set o_Overflow; FIFO contents unchanged.
REQ-017 Write and pop on the same edge SHALL both occur, including when full; o_Count unchanged.
REQ-018 FSM states: IDLE, WAIT_DONE, GAP.
REQ-019 IDLE: if o_Empty=0 and i_TX_Active=0, SHALL pop head into o_TX_Byte, pulse o_TX_DV for one cycle, go WAIT_DONE.
REQ-020 WAIT_DONE: on i_TX_Done=1 SHALL go GAP; all other inputs ignored.
REQ-021 GAP: SHALL hold one cycle, then go IDLE (lets serializer drop Active).
REQ-022 Latency: byte written at edge k into an empty FIFO with idle serializer SHALL produce o_TX_DV high for exactly the cycle after edge k+1.
REQ-023 Output order SHALL equal write order; no byte duplicated or lost except by REQ-016.
REQ-024 i_Clr_Ovf coincident with an overflowing write: set SHALL win.

Reset
REQ-025 Reset SHALL force: pointers=0, o_Count=0, o_Empty=1, o_Full=0, o_TX_DV=0, o_TX_Byte=8'h00, o_Overflow=0, FSM=IDLE.
REQ-026 Reset mid-transmission SHALL discard buffered data and in-flight state; i_TX_Done after reset in IDLE SHALL be ignored.

Configuration
REQ-027 Macro UART_TX_BUFFER_OVF_CNT_EN defined: port o_Ovf_Count (8 bits out) SHALL count dropped writes, saturate at 255, reset to 0, clear on i_Clr_Ovf.
REQ-028 Macro undefined: o_Ovf_Count port and counter SHALL be absent; o_Overflow unaffected.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state encoding (2-bit), byte width constant (8) and default DEPTH.
REQ-030 Storage SHALL be a sub-module uart_fifo_mem (dual-port register array, sync write, async read); FSM and pointers in the top.

Verification
REQ-031 Single byte 8'hA5 written into empty FIFO, i_TX_Active=0 -> o_TX_DV pulse one cycle after next edge, o_TX_Byte=8'hA5, o_Empty=1 after.
REQ-032 Write 16 bytes 8'h00..8'h0F back-to-back with serializer held active -> o_Full=1, o_Count=16; 17th write 8'hFF -> o_Overflow=1, drained output 8'h00..8'h0F in order.
REQ-033 FIFO full, pop and write 8'h55 same edge -> o_Count stays 16, 8'h55 emerges last.
REQ-034 Serializer model returning i_TX_Done 100 cycles after launch, 3 bytes queued -> exactly 3 o_TX_DV pulses, each ≥1 GAP cycle after the previous i_TX_Done.
REQ-035 Assert i_Rst_L=0 while in WAIT_DONE with 5 bytes queued -> o_Count=0, o_TX_DV=0 immediately; later i_TX_Done produces no launch.
REQ-036 With UART_TX_BUFFER_OVF_CNT_EN: 300 writes into a full, stalled FIFO -> o_Ovf_Count=255; i_Clr_Ovf -> 0, o_Overflow=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit buffer: FSM encoding, byte width, default depth.
`timescale 1ns/1ps

package uart_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Legacy-compatible 2-bit state encoding.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DONE = 2'd1;
    localparam logic [1:0] ST_GAP       = 2'd2;

endpackage

// File: rtl/uart_fifo_mem.sv
// Dual-port register array backing the transmit FIFO: synchronous write, asynchronous read.
`timescale 1ns/1ps

module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = BYTE_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART serializer with an IDLE/WAIT_DONE/GAP launch FSM.
// Define UART_TX_BUFFER_OVF_CNT_EN to add the saturating o_Ovf_Count drop counter.
`timescale 1ns/1ps

module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_L,
    input  logic                     i_Wr_DV,
    input  logic [BYTE_W-1:0]        i_Wr_Byte,
    output logic                     o_TX_DV,
    output logic [BYTE_W-1:0]        o_TX_Byte,
    input  logic                     i_TX_Active,
    input  logic                     i_TX_Done,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Full,
    output logic                     o_Empty,
    input  logic                     i_Clr_Ovf,
    output logic                     o_Overflow
`ifdef UART_TX_BUFFER_OVF_CNT_EN
   ,output logic [7:0]               o_Ovf_Count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [1:0]        state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [BYTE_W-1:0] head;
    logic              pop;
    logic              push;
    logic              drop;

    assign o_Count = count;
    assign o_Empty = (count == '0);
    assign o_Full  = (count == FULL_COUNT);

    // A pop frees a slot on the same edge, so a write while full still lands.
    assign pop  = (state == ST_IDLE) && !o_Empty && !i_TX_Active;
    assign push = i_Wr_DV && (!o_Full || pop);
    assign drop = i_Wr_DV && o_Full && !pop;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_mem (
        .clk     (i_Clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (i_Wr_Byte),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= '0;
            state     <= ST_IDLE;
        end else begin
            o_TX_DV <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                o_TX_Byte <= head;
                o_TX_DV   <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            case (state)
                ST_IDLE:      if (pop) state <= ST_WAIT_DONE;
                ST_WAIT_DONE: if (i_TX_Done) state <= ST_GAP;
                ST_GAP:       state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Overflow <= 1'b0;
        end else if (drop) begin
            o_Overflow <= 1'b1;
        end else if (i_Clr_Ovf) begin
            o_Overflow <= 1'b0;
        end
    end

`ifdef UART_TX_BUFFER_OVF_CNT_EN
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Ovf_Count <= '0;
        end else if (drop) begin
            if (i_Clr_Ovf) begin
                o_Ovf_Count <= 8'd1;
            end else if (o_Ovf_Count != 8'hFF) begin
                o_Ovf_Count <= o_Ovf_Count + 8'd1;
            end
        end else if (i_Clr_Ovf) begin
            o_Ovf_Count <= '0;
        end
    end
`else
    // Drop counter not built; o_Overflow alone records dropped writes.
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: scoreboard of written bytes checked at each launch.
`timescale 1ns/1ps

module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_dv;
    logic [7:0] wr_byte;
    logic       active;
    logic       done;
    logic       clr;

    logic       o_TX_DV;
    logic [7:0] o_TX_Byte;
    logic [4:0] o_Count;
    logic       o_Full;
    logic       o_Empty;
    logic       o_Overflow;
`ifdef UART_TX_BUFFER_OVF_CNT_EN
    logic [7:0] o_Ovf_Count;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulse_count = 0;
    int served = 0;
    logic [7:0] exp_q[$];
    int launch_cyc[$];
    int done_cyc[$];

    always #5 clk = ~clk;

    uart_tx_buffer #(.DEPTH(16)) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .i_TX_Active (active),
        .i_TX_Done   (done),
        .o_Count     (o_Count),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .i_Clr_Ovf   (clr),
        .o_Overflow  (o_Overflow)
`ifdef UART_TX_BUFFER_OVF_CNT_EN
       ,.o_Ovf_Count (o_Ovf_Count)
`endif
    );

    always @(posedge clk) begin
        if (done) done_cyc.push_back(cyc);
        cyc <= cyc + 1;
    end

    // Scoreboard: every launch must carry the oldest accepted byte.
    always @(negedge clk) begin
        if (rst_n && o_TX_DV) begin
            logic [7:0] exp;
            pulse_count++;
            launch_cyc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL launch_unexpected got=%h want=none", o_TX_Byte);
            end else begin
                exp = exp_q.pop_front();
                if (o_TX_Byte !== exp) begin
                    bad++;
                    $display("FAIL launch_byte got=%h want=%h", o_TX_Byte, exp);
                end
            end
        end
    end

    // Serializer model: wait for each launch, stay busy `delay` cycles, then pulse done.
    task automatic serve(input int n, input int delay);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            active = 1'b0;
            while (pulse_count <= served && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (pulse_count <= served) begin
                total++;
                bad++;
                $display("FAIL launch_timeout got=%0d want=%0d", pulse_count, served + 1);
                return;
            end
            active = 1'b1;
            repeat (delay) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            active = 1'b0;
            served++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (o_Count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", o_Count); end
        total++; if (o_Empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", o_Empty); end
        total++; if (o_Full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b want=0", o_Full); end
        total++; if (o_TX_DV !== 1'b0) begin bad++; $display("FAIL rst_txdv got=%b want=0", o_TX_DV); end
        total++; if (o_TX_Byte !== 8'h00) begin bad++; $display("FAIL rst_txbyte got=%h want=00", o_TX_Byte); end
        total++; if (o_Overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", o_Overflow); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        served = pulse_count;
        wr_dv = 1'b1; wr_byte = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_dv = 1'b0;
        total++; if (o_TX_DV !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", o_TX_DV); end
        total++; if (o_Count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d want=1", o_Count); end
        @(negedge clk);
        total++; if (o_TX_DV !== 1'b1) begin bad++; $display("FAIL single_launch got=%b want=1", o_TX_DV); end
        total++; if (o_Empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b want=1", o_Empty); end
        @(negedge clk);
        total++; if (o_TX_DV !== 1'b0) begin bad++; $display("FAIL single_pulse_width got=%b want=0", o_TX_DV); end
        total++; if (o_TX_Byte !== 8'hA5) begin bad++; $display("FAIL single_hold got=%h want=a5", o_TX_Byte); end
        serve(1, 5);
    endtask

    task automatic test_fill_overflow();
        served = pulse_count;
        active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_dv = 1'b1; wr_byte = 8'(i); exp_q.push_back(8'(i));
        end
        @(negedge clk);
        total++; if (o_Full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", o_Full); end
        total++; if (o_Count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d want=16", o_Count); end
        total++; if (o_Overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf got=%b want=0", o_Overflow); end
        wr_byte = 8'hFF;
        @(negedge clk);
        wr_dv = 1'b0;
        total++; if (o_Overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", o_Overflow); end
        total++; if (o_Count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", o_Count); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++; if (o_Overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", o_Overflow); end
        wr_dv = 1'b1; wr_byte = 8'hEE; clr = 1'b1;
        @(negedge clk);
        wr_dv = 1'b0; clr = 1'b0;
        total++; if (o_Overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b want=1", o_Overflow); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        // Pop and write on the same edge while full.
        active = 1'b0; wr_dv = 1'b1; wr_byte = 8'h55; exp_q.push_back(8'h55);
        @(negedge clk);
        wr_dv = 1'b0; active = 1'b1;
        total++; if (o_TX_DV !== 1'b1) begin bad++; $display("FAIL popwr_launch got=%b want=1", o_TX_DV); end
        total++; if (o_Count !== 5'd16) begin bad++; $display("FAIL popwr_count got=%0d want=16", o_Count); end
        total++; if (o_Overflow !== 1'b0) begin bad++; $display("FAIL popwr_no_ovf got=%b want=0", o_Overflow); end
        serve(17, 3);
        total++; if (o_Empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", o_Empty); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drain_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_paced();
        int start;
        start = pulse_count;
        served = pulse_count;
        launch_cyc.delete();
        done_cyc.delete();
        active = 1'b0;
        wr_dv = 1'b1; wr_byte = 8'h11; exp_q.push_back(8'h11);
        @(negedge clk); wr_byte = 8'h22; exp_q.push_back(8'h22);
        @(negedge clk); wr_byte = 8'h33; exp_q.push_back(8'h33);
        @(negedge clk); wr_dv = 1'b0;
        serve(3, 100);
        repeat (10) @(negedge clk);
        total++; if (pulse_count - start != 3) begin bad++; $display("FAIL paced_pulses got=%0d want=3", pulse_count - start); end
        total++; if (launch_cyc.size() != 3 || done_cyc.size() != 3) begin
            bad++; $display("FAIL paced_events got=%0d/%0d want=3/3", launch_cyc.size(), done_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (launch_cyc[i] - done_cyc[i-1] != 3) begin
                    bad++; $display("FAIL paced_gap got=%0d want=3", launch_cyc[i] - done_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        active = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_dv = 1'b1; wr_byte = 8'hC0 + 8'(i); exp_q.push_back(8'hC0 + 8'(i));
        end
        @(negedge clk);
        wr_dv = 1'b0; active = 1'b0;
        @(negedge clk);
        total++; if (o_TX_DV !== 1'b1) begin bad++; $display("FAIL mid_launch got=%b want=1", o_TX_DV); end
        total++; if (o_Count !== 5'd5) begin bad++; $display("FAIL mid_count got=%0d want=5", o_Count); end
        active = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if (o_Count !== 5'd0) begin bad++; $display("FAIL mid_rst_count got=%0d want=0", o_Count); end
        total++; if (o_TX_DV !== 1'b0) begin bad++; $display("FAIL mid_rst_txdv got=%b want=0", o_TX_DV); end
        total++; if (o_Empty !== 1'b1) begin bad++; $display("FAIL mid_rst_empty got=%b want=1", o_Empty); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        served = pulse_count;
        active = 1'b0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (pulse_count != served) begin bad++; $display("FAIL mid_stray_launch got=%0d want=%0d", pulse_count, served); end
        wr_dv = 1'b1; wr_byte = 8'h3C; exp_q.push_back(8'h3C);
        @(negedge clk);
        wr_dv = 1'b0;
        serve(1, 2);
        total++; if (o_Empty !== 1'b1) begin bad++; $display("FAIL mid_recover_empty got=%b want=1", o_Empty); end
    endtask

`ifdef UART_TX_BUFFER_OVF_CNT_EN
    task automatic test_ovf_count();
        served = pulse_count;
        active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_dv = 1'b1; wr_byte = 8'h80 + 8'(i); exp_q.push_back(8'h80 + 8'(i));
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            wr_byte = 8'hAA;
        end
        @(negedge clk);
        wr_dv = 1'b0;
        total++; if (o_Ovf_Count !== 8'd255) begin bad++; $display("FAIL ovfcnt_sat got=%0d want=255", o_Ovf_Count); end
        total++; if (o_Overflow !== 1'b1) begin bad++; $display("FAIL ovfcnt_flag got=%b want=1", o_Overflow); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++; if (o_Ovf_Count !== 8'd0) begin bad++; $display("FAIL ovfcnt_clear got=%0d want=0", o_Ovf_Count); end
        total++; if (o_Overflow !== 1'b0) begin bad++; $display("FAIL ovfcnt_flag_clear got=%b want=0", o_Overflow); end
        serve(16, 2);
    endtask
`endif

    initial begin
        rst_n = 1'b0; wr_dv = 1'b0; wr_byte = 8'h00;
        active = 1'b0; done = 1'b0; clr = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_paced();
        test_reset_mid();
`ifdef UART_TX_BUFFER_OVF_CNT_EN
        test_ovf_count();
`endif
        repeat (5) @(negedge clk);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL final_queue got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
